imm_decode_stage: RTL
=====================

# imm_decode_stage

Registered, handshaked immediate-decode stage that succeeds the combinational immediate extender. It takes a 32-bit RISC-V instruction with a valid/ready handshake and extracts its immediate, sign- or zero-extended to a parametrised XLEN. It also reports the immediate format and an illegal-opcode flag. It sits between fetch and the register-read/execute stage, with a 2-entry skid buffer so that the stage sustains full throughput under back-pressure, and a synchronous flush for branch redirects.

## Interface
- XLEN, 32: datapath width; 32 or 64. 64 enables the OP-IMM-32 and OP-32 opcodes and RV64 sign extension.
- TAG_W, 32: width of the sideband tag (normally the PC) carried alongside each instruction.
- clk  in  1  clock
- rst_n  in  1  asynchronous, active-low reset
- flush  in  1  synchronous kill of all held entries
- in_valid  in  1  upstream instruction valid
- in_ready  out  1  stage can accept an instruction
- in_instr  in  32  instruction word
- in_tag  in  TAG_W  sideband tag
- out_valid  out  1  decoded entry valid
- out_ready  in  1  downstream accepts the entry
- out_imm  out  XLEN  extended immediate
- out_fmt  out  3  imm_fmt_t: NONE, I, S, B, U, J, Z
- out_illegal  out  1  opcode unrecognised for this XLEN
- out_tag  out  TAG_W  tag of the presented entry

## Operation
- Accept occurs when in_valid && in_ready. Emit occurs when out_valid && out_ready.
- Decode is keyed on opcode in_instr[6:0]:
  - I-type: 0010011, 0000011, 1100111 → {sext, instr[31:20]}.
  - S-type: 0100011 → {sext, [31:25], [11:7]}.
  - B-type: 1100011 → {sext, [31], [7], [30:25], [11:8], 0}.
  - J-type: 1101111 → {sext, [31], [19:12], [20], [30:21], 0}.
  - U-type: 0110111, 0010111 → {[31:12], 12'b0}, sign-extended from bit 31 when XLEN=64.
  - Z: 1110011 with funct3[2]=1 → zero-extended instr[19:15].
  - Other SYSTEM, FENCE (0001111) and OP (0110011) → fmt NONE, imm 0, illegal 0.
  - XLEN=64 only: OP-IMM-32 (0011011) → I; OP-32 (0111011) → NONE.
  - Any other opcode, including low bits != 11 → fmt NONE, imm 0, illegal 1.
- The sign bit is always instr[31], replicated to XLEN.
- Skid buffer: a main register drives the outputs; a skid register catches the one beat accepted while the output is stalled.
  - in_ready = !skid_valid. This is registered, with no combinational path from out_ready.
  - On emit with the skid full, the skid moves to main.
  - Ordering is strictly FIFO. No entry is dropped or duplicated.
- flush: on that clock edge, main_valid and skid_valid clear. An in_valid beat presented in the same cycle is discarded. flush overrides a simultaneous emit and accept.
- While out_valid && !out_ready, all out_* signals hold stable.

## Timing
- Latency: accept at edge N → out_valid high after edge N; combinational decode is applied before the main register.
- Throughput: 1 instruction per cycle while out_ready is high.
- Reset values (asynchronous, rst_n low):
  - out_valid 0, out_imm 0, out_fmt NONE, out_illegal 0, out_tag 0.
  - Both valid bits 0, so in_ready reads 1.
- Reset mid-operation: held entries are lost. Operation resumes on the first edge after rst_n deasserts.
- Stall occupancy:
  - Main full, skid empty: in_ready = 1, and one more beat may be accepted.
  - Both full: in_ready = 0.
  - Emit with both full: skid → main, and in_ready returns to 1 the next cycle.
- Data registers may be non-reset; the output values above are forced via the valid-gated reset.

## Structure
- imm_pkg holds:
  - The imm_fmt_t enum (3-bit).
  - Opcode localparams: OPC_OP_IMM, OPC_LOAD, OPC_JALR, OPC_STORE, OPC_BRANCH, OPC_JAL, OPC_LUI, OPC_AUIPC, OPC_SYSTEM, OPC_MISC_MEM, OPC_OP, OPC_OP_IMM_32, OPC_OP_32.
  - An entry struct {imm, fmt, illegal, tag}.
- imm_extract is a combinational sub-module (parameter XLEN) that produces imm, fmt and illegal from the instruction.
- The top level contains only the skid/handshake/flush control and the two entry registers.

## Test plan
- Basic extraction, XLEN=32:
  - ADDI 0xFFF00093 → one cycle later imm 0xFFFFFFFF, fmt I, illegal 0.
  - BEQ 0xFE000EE3 → imm 0xFFFFFFFC, fmt B.
- RV64 sign extension, XLEN=64: LUI 0x800002B7 → imm 0xFFFFFFFF80000000, fmt U. With XLEN=32 → 0x80000000.
- CSR and illegal opcodes:
  - CSRRWI 0x300FD073 → imm 0x1F, fmt Z.
  - 0x00000000 → illegal 1, fmt NONE.
  - 0x0000001B with XLEN=32 → illegal 1.
- Back-pressure:
  - Hold out_ready low and stream 3 beats (tags 1, 2, 3): tags 1 and 2 are accepted; in_ready drops after tag 2 is accepted; tag 3 is stalled upstream.
  - Raise out_ready: tags emit in order 1, 2, 3, with no gaps once flowing.
- Flush: with both entries full and in_valid high, assert flush for 1 cycle → out_valid 0 on the next cycle, in_ready 1, and the concurrent beat never appears at the output.
- Reset mid-stream: pull rst_n low asynchronously between edges → out_valid 0 immediately, and the first beat after release has a 1-cycle latency.

Source files
------------

// File: rtl/imm_pkg.sv
// Shared types and constants for the immediate-decode stage.
//   imm_fmt_t : immediate format reported alongside each decoded instruction
//   OPC_*     : RISC-V major opcodes recognised by the extractor
//   entry_t   : one held pipeline entry; imm/tag sized for the widest build
package imm_pkg;

    typedef enum logic [2:0] {
        FMT_NONE = 3'd0,
        FMT_I    = 3'd1,
        FMT_S    = 3'd2,
        FMT_B    = 3'd3,
        FMT_U    = 3'd4,
        FMT_J    = 3'd5,
        FMT_Z    = 3'd6
    } imm_fmt_t;

    localparam logic [6:0] OPC_OP_IMM    = 7'b0010011;
    localparam logic [6:0] OPC_LOAD      = 7'b0000011;
    localparam logic [6:0] OPC_JALR      = 7'b1100111;
    localparam logic [6:0] OPC_STORE     = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH    = 7'b1100011;
    localparam logic [6:0] OPC_JAL       = 7'b1101111;
    localparam logic [6:0] OPC_LUI       = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC     = 7'b0010111;
    localparam logic [6:0] OPC_SYSTEM    = 7'b1110011;
    localparam logic [6:0] OPC_MISC_MEM  = 7'b0001111;
    localparam logic [6:0] OPC_OP        = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM_32 = 7'b0011011;
    localparam logic [6:0] OPC_OP_32     = 7'b0111011;

    // Storage widths of an entry; a build uses the low XLEN / TAG_W bits.
    localparam int IMM_W_MAX = 64;
    localparam int TAG_W_MAX = 64;

    typedef struct packed {
        logic [IMM_W_MAX-1:0] imm;
        imm_fmt_t             fmt;
        logic                 illegal;
        logic [TAG_W_MAX-1:0] tag;
    } entry_t;

endpackage

// File: rtl/imm_extract.sv
// Combinational immediate extractor.
//   instr   : 32-bit instruction word
//   imm     : immediate, sign- or zero-extended to XLEN
//   fmt     : immediate format
//   illegal : opcode not recognised for this XLEN
module imm_extract
    import imm_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [31:0]     instr,
    output logic [XLEN-1:0] imm,
    output imm_fmt_t        fmt,
    output logic            illegal
);

    // Every format is first built as a 32-bit value whose bit 31 is the
    // sign, so a single signed widening covers RV32 and RV64 alike; the
    // zero-extended CSR immediate has bit 31 clear and widens with zeros.
    logic [31:0] imm32_s;
    logic        sign_s;

    assign sign_s = instr[31];

    // Opcode decode into format, 32-bit immediate and illegal flag.
    always_comb begin
        imm32_s = 32'd0;
        fmt     = FMT_NONE;
        illegal = 1'b0;
        case (instr[6:0])
            OPC_OP_IMM, OPC_LOAD, OPC_JALR: begin
                imm32_s = {{20{sign_s}}, instr[31:20]};
                fmt     = FMT_I;
            end
            OPC_STORE: begin
                imm32_s = {{20{sign_s}}, instr[31:25], instr[11:7]};
                fmt     = FMT_S;
            end
            OPC_BRANCH: begin
                imm32_s = {{20{sign_s}}, instr[7], instr[30:25], instr[11:8], 1'b0};
                fmt     = FMT_B;
            end
            OPC_JAL: begin
                imm32_s = {{12{sign_s}}, instr[19:12], instr[20], instr[30:21], 1'b0};
                fmt     = FMT_J;
            end
            OPC_LUI, OPC_AUIPC: begin
                imm32_s = {instr[31:12], 12'd0};
                fmt     = FMT_U;
            end
            OPC_SYSTEM: begin
                // funct3[2] selects the CSR-immediate forms (uimm in rs1 field).
                if (instr[14]) begin
                    imm32_s = {27'd0, instr[19:15]};
                    fmt     = FMT_Z;
                end else begin
                    fmt     = FMT_NONE;
                end
            end
            OPC_MISC_MEM, OPC_OP: begin
                fmt = FMT_NONE;
            end
            OPC_OP_IMM_32: begin
                if (XLEN == 64) begin
                    imm32_s = {{20{sign_s}}, instr[31:20]};
                    fmt     = FMT_I;
                end else begin
                    illegal = 1'b1;
                end
            end
            OPC_OP_32: begin
                if (XLEN == 64) begin
                    fmt     = FMT_NONE;
                end else begin
                    illegal = 1'b1;
                end
            end
            default: begin
                illegal = 1'b1;
            end
        endcase
    end

    assign imm = XLEN'($signed(imm32_s));

endmodule

// File: rtl/imm_decode_stage.sv
// Registered, handshaked immediate-decode stage with a 2-entry skid buffer.
//   clk, rst_n             : clock, asynchronous active-low reset
//   flush                  : synchronous kill of held entries and the input beat
//   in_valid/in_ready      : upstream handshake; in_ready is a register output
//   in_instr, in_tag       : instruction word and its sideband tag
//   out_valid/out_ready    : downstream handshake
//   out_imm, out_fmt,
//   out_illegal, out_tag   : decoded entry currently presented
module imm_decode_stage
    import imm_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int TAG_W = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      in_instr,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [XLEN-1:0]  out_imm,
    output imm_fmt_t         out_fmt,
    output logic             out_illegal,
    output logic [TAG_W-1:0] out_tag
);

    logic [XLEN-1:0] ext_imm_s;
    imm_fmt_t        ext_fmt_s;
    logic            ext_illegal_s;
    entry_t          entry_s;
    entry_t          main_r;
    entry_t          skid_r;
    logic            main_valid_r;
    logic            skid_valid_r;
    logic            accept_s;
    logic            emit_s;
    logic            load_main_in_s;
    logic            load_main_skid_s;
    logic            load_skid_s;
    logic            unused_bits_s;

    imm_extract #(.XLEN(XLEN)) u_extract (
        .instr   (in_instr),
        .imm     (ext_imm_s),
        .fmt     (ext_fmt_s),
        .illegal (ext_illegal_s)
    );

    // Pack the freshly decoded instruction into an entry.
    always_comb begin
        entry_s         = '0;
        entry_s.imm     = IMM_W_MAX'(ext_imm_s);
        entry_s.fmt     = ext_fmt_s;
        entry_s.illegal = ext_illegal_s;
        entry_s.tag     = TAG_W_MAX'(in_tag);
    end

    // The skid can only be empty-to-full while main is stalled, so
    // in_ready depends on the skid bit alone and never on out_ready.
    assign accept_s = in_valid && !skid_valid_r;
    assign emit_s   = main_valid_r && out_ready;

    // Data-path steering: main refills from the skid first to keep FIFO order.
    always_comb begin
        load_main_in_s   = 1'b0;
        load_main_skid_s = 1'b0;
        load_skid_s      = 1'b0;
        if (!main_valid_r) begin
            load_main_in_s = accept_s;
        end else if (emit_s) begin
            if (skid_valid_r) begin
                load_main_skid_s = 1'b1;
            end else begin
                load_main_in_s = accept_s;
            end
        end else begin
            load_skid_s = accept_s;
        end
    end

    // Occupancy bits; flush wins over any concurrent emit or accept.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            main_valid_r <= 1'b0;
            skid_valid_r <= 1'b0;
        end else if (flush) begin
            main_valid_r <= 1'b0;
            skid_valid_r <= 1'b0;
        end else begin
            if (load_main_in_s || load_main_skid_s) begin
                main_valid_r <= 1'b1;
            end else if (emit_s) begin
                main_valid_r <= 1'b0;
            end
            if (load_skid_s) begin
                skid_valid_r <= 1'b1;
            end else if (load_main_skid_s) begin
                skid_valid_r <= 1'b0;
            end
        end
    end

    // Entry payload registers; flush only clears occupancy, payload is don't-care.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            main_r <= '0;
            skid_r <= '0;
        end else begin
            if (load_main_skid_s) begin
                main_r <= skid_r;
            end else if (load_main_in_s) begin
                main_r <= entry_s;
            end
            if (load_skid_s) begin
                skid_r <= entry_s;
            end
        end
    end

    assign in_ready    = !skid_valid_r;
    assign out_valid   = main_valid_r;
    assign out_imm     = main_r.imm[XLEN-1:0];
    assign out_fmt     = main_r.fmt;
    assign out_illegal = main_r.illegal;
    assign out_tag     = main_r.tag[TAG_W-1:0];

    // Storage bits above the configured widths are never presented.
    assign unused_bits_s = ^{main_r.imm, main_r.tag};

endmodule
